// File: rtl/nbit_univ_reg_async_rst_if.sv
// Control/data bundle for the universal register: the master drives operations
// and observes Q/SO/Z, and the slave (the register) does the reverse.
interface nbit_univ_reg_async_rst_if #(
  parameter int WIDTH = 8
) ();
  logic             CE;
  logic             SCLR;
  logic [2:0]       MODE;
  logic [WIDTH-1:0] D;
  logic             SIL;
  logic             SIR;
  logic [WIDTH-1:0] Q;
  logic             SO;
  logic             Z;

  modport master (
    output CE, SCLR, MODE, D, SIL, SIR,
    input  Q, SO, Z
  );

  modport slave (
    input  CE, SCLR, MODE, D, SIL, SIR,
    output Q, SO, Z
  );
endinterface

// File: rtl/nbit_univ_reg_async_rst.sv
// WIDTH-bit universal register: load, shift/rotate both ways, increment/decrement,
// with a registered shift-out/carry bit and a zero flag decoded from Q.
module nbit_univ_reg_async_rst #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input logic                       clk,
  input logic                       R,
  nbit_univ_reg_async_rst_if.slave  bus
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_INC  = 3'b110,
    M_DEC  = 3'b111
  } mode_e;

  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  mode_e            mode;

  assign mode = mode_e'(bus.MODE);

  always_comb begin
    q_d  = q_q;
    so_d = so_q;
    if (bus.SCLR) begin
      q_d  = '0;
      so_d = 1'b0;
    end else if (bus.CE) begin
      case (mode)
        M_HOLD: begin
          q_d  = q_q;
          so_d = so_q;
        end
        M_LOAD: begin
          q_d  = bus.D;
          so_d = 1'b0;
        end
        M_SHL: begin
          q_d  = {q_q[WIDTH-2:0], bus.SIL};
          so_d = q_q[WIDTH-1];
        end
        M_SHR: begin
          q_d  = {bus.SIR, q_q[WIDTH-1:1]};
          so_d = q_q[0];
        end
        M_ROL: begin
          q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          so_d = q_q[WIDTH-1];
        end
        M_ROR: begin
          q_d  = {q_q[0], q_q[WIDTH-1:1]};
          so_d = q_q[0];
        end
        // One extra bit on the adder: its MSB is the carry (inc) or borrow (dec).
        M_INC: {so_d, q_d} = {1'b0, q_q} + ONE_EXT;
        M_DEC: {so_d, q_d} = {1'b0, q_q} - ONE_EXT;
        default: begin
          q_d  = q_q;
          so_d = so_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      q_q  <= RESET_VALUE;
      so_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      so_q <= so_d;
    end
  end

  assign bus.Q  = q_q;
  assign bus.SO = so_q;
  assign bus.Z  = (q_q == '0);

endmodule

// File: tb/tb_nbit_univ_reg_async_rst.sv
// Directed plus randomized checks of two register configurations against a
// plain-arithmetic reference model.
module tb_nbit_univ_reg_async_rst;

  logic clk = 1'b0;
  logic rA, rB;
  int   passed = 0;
  int   total  = 0;
  int   mqa, msoa, mqb, msob;

  always #5 clk = ~clk;

  nbit_univ_reg_async_rst_if #(.WIDTH(8)) busA ();
  nbit_univ_reg_async_rst_if #(.WIDTH(2)) busB ();

  nbit_univ_reg_async_rst #(.WIDTH(8), .RESET_VALUE(8'hFF)) dutA (
    .clk (clk),
    .R   (rA),
    .bus (busA)
  );

  nbit_univ_reg_async_rst #(.WIDTH(2), .RESET_VALUE(2'b00)) dutB (
    .clk (clk),
    .R   (rB),
    .bus (busB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Next state from the operation table, using integer arithmetic on width w.
  function automatic void model(input int w, inout int q, inout int so,
                                input bit ce, input bit sclr, input int mode,
                                input int d, input bit sil, input bit sir);
    int mask, msb, lsb;
    mask = (1 << w) - 1;
    msb  = (q >> (w - 1)) & 1;
    lsb  = q & 1;
    if (sclr) begin
      q = 0; so = 0;
    end else if (ce) begin
      case (mode)
        1: begin q = d & mask; so = 0; end
        2: begin so = msb; q = ((q << 1) | int'(sil)) & mask; end
        3: begin so = lsb; q = (q >> 1) | (int'(sir) << (w - 1)); end
        4: begin so = msb; q = ((q << 1) | msb) & mask; end
        5: begin so = lsb; q = (q >> 1) | (lsb << (w - 1)); end
        6: begin so = (q == mask) ? 1 : 0; q = (q + 1) & mask; end
        7: begin so = (q == 0) ? 1 : 0; q = (q - 1) & mask; end
        default: ;
      endcase
    end
  endfunction

  task automatic checkA(input string tag);
    chk({tag, ".Q"},  32'(busA.Q),  32'(mqa));
    chk({tag, ".SO"}, 32'(busA.SO), 32'(msoa));
    chk({tag, ".Z"},  32'(busA.Z),  32'(mqa == 0));
  endtask

  task automatic checkB(input string tag);
    chk({tag, ".Q"},  32'(busB.Q),  32'(mqb));
    chk({tag, ".SO"}, 32'(busB.SO), 32'(msob));
    chk({tag, ".Z"},  32'(busB.Z),  32'(mqb == 0));
  endtask

  // Entered just after an edge; presents inputs, takes one edge, checks.
  task automatic stepA(input bit ce, input bit sclr, input int mode, input int d,
                       input bit sil, input bit sir, input string tag);
    busA.CE = ce; busA.SCLR = sclr; busA.MODE = 3'(mode);
    busA.D = 8'(d); busA.SIL = sil; busA.SIR = sir;
    @(posedge clk); #1;
    model(8, mqa, msoa, ce, sclr, mode, d, sil, sir);
    checkA(tag);
  endtask

  task automatic stepB(input bit ce, input bit sclr, input int mode, input int d,
                       input bit sil, input bit sir, input string tag);
    busB.CE = ce; busB.SCLR = sclr; busB.MODE = 3'(mode);
    busB.D = 2'(d); busB.SIL = sil; busB.SIR = sir;
    @(posedge clk); #1;
    model(2, mqb, msob, ce, sclr, mode, d, sil, sir);
    checkB(tag);
  endtask

  initial begin
    busA.CE = 1'b0; busA.SCLR = 1'b0; busA.MODE = 3'd0; busA.D = '0; busA.SIL = 1'b0; busA.SIR = 1'b0;
    busB.CE = 1'b0; busB.SCLR = 1'b0; busB.MODE = 3'd0; busB.D = '0; busB.SIL = 1'b0; busB.SIR = 1'b0;
    rA = 1'b1; rB = 1'b1;
    mqa = 8'hFF; msoa = 0; mqb = 0; msob = 0;
    #2;
    checkA("rstA");
    chk("rstA.Zconst", 32'(busA.Z), 32'd0);
    checkB("rstB");
    chk("rstB.Zconst", 32'(busB.Z), 32'd1);
    rA = 1'b0; rB = 1'b0;

    // Increment sequence interrupted by an asynchronous reset between edges.
    stepA(1, 0, 6, 0, 0, 0, "inc0");
    stepA(1, 0, 6, 0, 0, 0, "inc1");
    #2 rA = 1'b1;
    #1;
    mqa = 8'hFF; msoa = 0;
    checkA("asyncR");
    chk("asyncR.Qconst", 32'(busA.Q), 32'hFF);
    #1 rA = 1'b0;
    stepA(1, 0, 6, 0, 0, 0, "postR_inc");
    chk("postR_inc.Qconst", 32'(busA.Q), 32'h00);

    // Load and clock-enable hold.
    stepA(1, 0, 1, 8'hA5, 0, 0, "load");
    for (int i = 0; i < 3; i++) stepA(0, 0, 1, 8'h00, 0, 0, "ce0hold");
    chk("ce0hold.Qconst", 32'(busA.Q), 32'hA5);

    // Shifts and rotates.
    stepA(1, 0, 2, 0, 1, 0, "shl");
    chk("shl.Qconst", 32'(busA.Q), 32'h4B);
    stepA(1, 0, 3, 0, 0, 0, "shr");
    chk("shr.Qconst", 32'(busA.Q), 32'h25);
    stepA(1, 0, 1, 8'h81, 0, 0, "load81");
    stepA(1, 0, 4, 0, 0, 0, "rol");
    chk("rol.Qconst", 32'(busA.Q), 32'h03);
    stepA(1, 0, 5, 0, 0, 0, "ror");
    chk("ror.Qconst", 32'(busA.Q), 32'h81);

    // Wrap-around in both directions.
    stepA(1, 0, 1, 8'hFF, 0, 0, "loadFF");
    stepA(1, 0, 6, 0, 0, 0, "incwrap");
    stepA(1, 0, 7, 0, 0, 0, "decwrap");
    stepA(1, 0, 7, 0, 0, 0, "decFE");
    chk("decFE.Qconst", 32'(busA.Q), 32'hFE);

    // Synchronous clear beats CE=0; reset beats clear.
    stepA(0, 1, 1, 8'h5A, 0, 0, "sclr");
    busA.SCLR = 1'b1; rA = 1'b1;
    @(posedge clk); #1;
    mqa = 8'hFF; msoa = 0;
    checkA("sclr_and_R");
    rA = 1'b0; busA.SCLR = 1'b0;
    stepA(1, 0, 0, 0, 0, 0, "holdAfterR");

    // Narrow configuration counts 0,1,2,3,0.
    for (int i = 0; i < 4; i++) stepB(1, 0, 6, 0, 0, 0, "Bcount");
    chk("Bcount.Qconst", 32'(busB.Q), 32'd0);
    chk("Bcount.SOconst", 32'(busB.SO), 32'd1);

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        #2 rA = 1'b1;
        #1 mqa = 8'hFF; msoa = 0;
        checkA("rndAsyncR");
        #1 rA = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        stepB($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), "rndB");
        busB.CE = 1'b0; busB.SCLR = 1'b0;
      end else begin
        stepA($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, int'($urandom_range(0, 7)),
              int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom), "rndA");
        busA.CE = 1'b0; busA.SCLR = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nbit_univ_reg_async_rst.md
# nbit_univ_reg_async_rst

Parametrised universal register. It generalises the team's fixed-width clock-enabled flip-flop registers to WIDTH bits and adds the following:
- a programmable reset value;
- synchronous clear;
- parallel load;
- shift and rotate in both directions;
- increment and decrement;
- registered serial-out/carry and zero flags.

It sits wherever the datapath needs a loadable, shiftable or counting register: serial converters, loop counters, scan-style data capture.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range is 2 and above.
- RESET_VALUE, {WIDTH{1'b1}}, value Q takes while R is asserted.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- R  input  1  reset; one clock; reset is asynchronous and active-high.
- CE  input  1  clock enable; when low, all state holds (SCLR excepted).
- SCLR  input  1  synchronous clear, active-high; overrides CE.
- MODE  input  3  operation select; see Operation.
- D  input  WIDTH  parallel load data.
- SIL  input  1  serial input for shift-left; enters at bit 0.
- SIR  input  1  serial input for shift-right; enters at bit WIDTH-1.
- Q  output  WIDTH  register contents.
- SO  output  1  registered shifted-out bit, carry or borrow of the last operation.
- Z  output  1  zero flag; equals (Q == 0), decoded from registered Q.

## Operation
Priority at each rising clk edge is R, then SCLR, then CE, then MODE.

Priority rules:
- R=1: Q=RESET_VALUE and SO=0, immediately, independent of clk. While R is held, the register holds there.
- SCLR=1 (R=0): Q=0, SO=0, regardless of CE and MODE.
- CE=0 (R=0, SCLR=0): Q and SO hold; MODE, D, SIL and SIR are ignored.

MODE actions when CE=1. "Old" means the value before the edge.
- 000 hold: Q and SO unchanged.
- 001 load: Q=D, SO=0.
- 010 shift left: Q={Q[W-2:0],SIL}, SO=old Q[W-1].
- 011 shift right: Q={SIR,Q[W-1:1]}, SO=old Q[0].
- 100 rotate left: Q={Q[W-2:0],Q[W-1]}, SO=old Q[W-1].
- 101 rotate right: Q={Q[0],Q[W-1:1]}, SO=old Q[0].
- 110 increment: Q=Q+1 modulo 2^WIDTH, SO=1 only when old Q is all ones (carry out).
- 111 decrement: Q=Q-1 modulo 2^WIDTH, SO=1 only when old Q is 0 (borrow out).

Arithmetic and flags:
- Increment and decrement are computed in WIDTH+1 bits; the MSB of the result becomes SO and the low WIDTH bits become Q.
- No saturation; wrap-around is the required behaviour.
- Z is combinational from the Q register only, never from inputs. It is valid in the same cycle Q changes.

## Timing
- Latency: every operation takes effect at the first rising edge where it is presented; Q, SO and Z are visible after that edge.
- No multi-cycle operations and no internal state beyond Q and SO.
- Reset values: Q=RESET_VALUE, SO=0, Z=(RESET_VALUE==0).
- R assertion is asynchronous: outputs change without a clock edge, including mid-operation, and any in-flight operation is discarded.
- R deassertion: the first rising edge with R=0 performs a normal operation. There is no extra recovery cycle.
- R and SCLR together: R wins, so Q=RESET_VALUE.
- SCLR with CE=0: the clear still occurs.
- Back-to-back operations in consecutive cycles are always legal. Each edge operates on the Q produced by the previous edge.
- MODE, D, SIL, SIR and SCLR are sampled only at the edge. No combinational path from inputs to Q, SO or Z.

## Test plan
Use WIDTH=8, RESET_VALUE=8'hFF unless stated.
- Assert R between edges during an increment sequence -> Q=8'hFF, SO=0, Z=0 with no clk edge. Release R and apply MODE=110 -> next edge Q=8'h00, SO=1, Z=1.
- MODE=001, D=8'hA5, CE=1 -> Q=8'hA5, SO=0. Then CE=0, MODE=001, D=8'h00 for 3 edges -> Q stays 8'hA5.
- From Q=8'hA5: MODE=010, SIL=1 -> Q=8'h4B, SO=1. Then MODE=011, SIR=0 -> Q=8'h25, SO=1.
- From Q=8'h81: MODE=100 -> Q=8'h03, SO=1. Then MODE=101 -> Q=8'h81, SO=1.
- From Q=8'hFF: MODE=110 -> Q=8'h00, SO=1, Z=1. Then MODE=111 -> Q=8'hFF, SO=1, Z=0. Then MODE=111 -> Q=8'hFE, SO=0.
- SCLR=1, CE=0, MODE=001, D=8'h5A -> Q=8'h00, SO=0, Z=1. SCLR=1 with R=1 -> Q=8'hFF. Repeat with WIDTH=2, RESET_VALUE=2'b00 -> after reset Z=1, and MODE=110 counts 0,1,2,3,0.
